eight_bit_alu: RTL and testbench
================================

# eight_bit_alu

Registered 8-bit arithmetic/logic unit with carry, zero, sign and overflow flags. It is the datapath execution unit: it takes two operands, a carry-in and a 3-bit opcode, and presents the result and flags one clock later. It is a leaf block with no memory beyond its output register.

## Interface
Parameters: none; width is fixed at 8.
- clk  in  1  rising-edge clock
- rst  in  1  asynchronous, active-high reset
- in_valid  in  1  qualifies a, b, cin and opcode for capture on this edge
- a  in  8  operand A, unsigned or two's complement
- b  in  8  operand B
- cin  in  1  carry-in for ADD, borrow-in for SUB
- opcode  in  3  operation select; see Operation
- res  out  8  registered result
- cout  out  1  registered carry / no-borrow flag
- zero  out  1  registered; 1 when res == 0
- sign  out  1  registered; equals res[7]
- overflow  out  1  registered signed-overflow flag
- out_valid  out  1  high one cycle after an accepted in_valid

One clock; reset is asynchronous and active-high.

## Operation
- 000 ADD: res = a + b + cin. cout = bit 8 of the 9-bit sum. overflow = (a[7] == b[7]) && (res[7] != a[7]).
- 001 SUB: res = a − b − cin, computed as a + ~b + !cin. cout = bit 8 of that sum, so 1 means no borrow. overflow = (a[7] != b[7]) && (res[7] != a[7]).
- 010 AND: res = a & b.
- 011 OR: res = a | b.
- 100 XOR: res = a ^ b.
- 101 NOT: res = ~a; b is ignored.
- 110 INC: res = a + 1; cin and b are ignored. cout = 1 only when a = 0xFF. overflow = 1 only when a = 0x7F.
- 111 DEC: res = a − 1, computed as a + 0xFF. cout = 0 only when a = 0x00. overflow = 1 only when a = 0x80.
- Logic ops (010–101): cout = 0 and overflow = 0.
- zero and sign are derived from the new res for every opcode.
- All arithmetic is modulo 256; wrap-around is reflected only in cout and overflow.

## Timing
- Latency is 1 cycle. When in_valid is high at a rising edge, all outputs update at that edge and out_valid goes high.
- When in_valid is low at an edge: res and the flags hold their previous values, and out_valid goes low.
- Back-to-back in_valid gives one result per cycle.
- Reset value of res, cout, zero, sign, overflow and out_valid is 0. Note that zero resets to 0 even though res = 0.
- Asserting rst mid-stream clears the outputs immediately, without waiting for a clock edge, and drops any operation in flight.
- The first edge after rst deasserts behaves normally.
- Inputs must be stable across the setup/hold window of the sampling edge. There is no combinational path from inputs to outputs.

## Structure
- Package eight_bit_alu_pkg holds:
  - the opcode enum: OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR, OP_NOT, OP_INC, OP_DEC
  - the width constant DATA_W = 8
- One sub-module, alu_addsub: a 9-bit adder taking x, y and carry_in, returning sum[7:0], carry and overflow.
  - It is shared by ADD, SUB, INC and DEC through operand and carry muxing.
- The top level contains:
  - the opcode decode
  - the logic unit
  - the result mux
  - flag generation
  - the output register with async reset

## Test plan
- Reset: assert rst asynchronously between edges → all outputs read 0 immediately. Release rst → outputs stay 0 until the first valid op.
- ADD 10 + 5, cin = 0 → res = 15, cout = 0, zero = 0, sign = 0, overflow = 0.
- ADD edge cases:
  - 0xFF + 0x01 → res = 0, cout = 1, zero = 1.
  - 0x7F + 0x01 → res = 0x80, sign = 1, overflow = 1.
- SUB cases:
  - 15 − 7, cin = 0 → res = 8, cout = 1.
  - 5 − 7 → res = 0xFE, cout = 0, sign = 1.
  - 0x80 − 0x01 → res = 0x7F, overflow = 1.
- Logic ops with a = 170, b = 85:
  - AND → res = 0, zero = 1.
  - OR → res = 255, sign = 1.
  - XOR → res = 255.
  - NOT a → res = 85.
  - cout = 0 and overflow = 0 for all four.
- INC and DEC, back-to-back:
  - INC 100 → 101.
  - DEC 100 → 99, cout = 1.
  - DEC 0 → 255, cout = 0.
  - INC 255 → 0, cout = 1, zero = 1.
  - Insert an in_valid = 0 gap → outputs hold and out_valid = 0.

Source files
------------

// File: rtl/eight_bit_alu_pkg.sv
// rtl/eight_bit_alu_pkg.sv - shared opcode encoding and width for the eight_bit_alu slice
package eight_bit_alu_pkg;

   localparam int DATA_W = 8;

   typedef enum logic [2:0] {
      OP_ADD = 3'b000,
      OP_SUB = 3'b001,
      OP_AND = 3'b010,
      OP_OR  = 3'b011,
      OP_XOR = 3'b100,
      OP_NOT = 3'b101,
      OP_INC = 3'b110,
      OP_DEC = 3'b111
   } opcode_e;

endpackage

// File: rtl/alu_addsub.sv
// rtl/alu_addsub.sv - 9-bit adder shared by ADD, SUB, INC and DEC
module alu_addsub
   import eight_bit_alu_pkg::*;
(
   input  logic [DATA_W-1:0] x,
   input  logic [DATA_W-1:0] y,
   input  logic              carry_in,
   output logic [DATA_W-1:0] sum,
   output logic              carry,
   output logic              overflow
);

   logic [DATA_W:0] full;

   assign full     = {1'b0, x} + {1'b0, y} + {{DATA_W{1'b0}}, carry_in};
   assign sum      = full[DATA_W-1:0];
   assign carry    = full[DATA_W];
   // Signed overflow: operands agree in sign but the sum does not.
   assign overflow = (x[DATA_W-1] == y[DATA_W-1]) && (sum[DATA_W-1] != x[DATA_W-1]);

endmodule

// File: rtl/eight_bit_alu.sv
// rtl/eight_bit_alu.sv - registered 8-bit ALU with carry, zero, sign and overflow flags
module eight_bit_alu
   import eight_bit_alu_pkg::*;
(
   input  logic       clk,
   input  logic       rst,
   input  logic       in_valid,
   input  logic [7:0] a,
   input  logic [7:0] b,
   input  logic       cin,
   input  logic [2:0] opcode,
   output logic [7:0] res,
   output logic       cout,
   output logic       zero,
   output logic       sign,
   output logic       overflow,
   output logic       out_valid
);

   opcode_e           op;
   logic [DATA_W-1:0] as_y;
   logic              as_c;
   logic [DATA_W-1:0] as_sum;
   logic              as_carry;
   logic              as_ovf;
   logic [DATA_W-1:0] res_next;
   logic              cout_next;
   logic              ovf_next;

   assign op = opcode_e'(opcode);

   // Subtraction and decrement reuse the adder via inverted/constant operands.
   always_comb begin
      as_y = b;
      as_c = cin;
      case (op)
         OP_SUB:  begin as_y = ~b;            as_c = ~cin; end
         OP_INC:  begin as_y = '0;            as_c = 1'b1; end
         OP_DEC:  begin as_y = {DATA_W{1'b1}}; as_c = 1'b0; end
         default: begin as_y = b;             as_c = cin;  end
      endcase
   end

   alu_addsub u_addsub (
      .x        (a),
      .y        (as_y),
      .carry_in (as_c),
      .sum      (as_sum),
      .carry    (as_carry),
      .overflow (as_ovf)
   );

   always_comb begin
      res_next  = as_sum;
      cout_next = 1'b0;
      ovf_next  = 1'b0;
      case (op)
         OP_ADD, OP_SUB, OP_INC, OP_DEC: begin
            res_next  = as_sum;
            cout_next = as_carry;
            ovf_next  = as_ovf;
         end
         OP_AND:  res_next = a & b;
         OP_OR:   res_next = a | b;
         OP_XOR:  res_next = a ^ b;
         OP_NOT:  res_next = ~a;
         default: res_next = as_sum;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         res       <= '0;
         cout      <= 1'b0;
         zero      <= 1'b0;
         sign      <= 1'b0;
         overflow  <= 1'b0;
         out_valid <= 1'b0;
      end else begin
         out_valid <= in_valid;
         if (in_valid) begin
            res      <= res_next;
            cout     <= cout_next;
            zero     <= (res_next == '0);
            sign     <= res_next[DATA_W-1];
            overflow <= ovf_next;
         end
      end
   end

endmodule

// File: tb/tb_eight_bit_alu.sv
// tb/tb_eight_bit_alu.sv - directed-vector self-checking bench for eight_bit_alu
module tb_eight_bit_alu;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       in_valid = 1'b0;
   logic [7:0] a = '0;
   logic [7:0] b = '0;
   logic       cin = 1'b0;
   logic [2:0] opcode = '0;
   logic [7:0] res;
   logic       cout, zero, sign, overflow, out_valid;

   int total = 0;
   int bad   = 0;

   // op, a, b, cin, expected {res, cout, zero, sign, overflow, out_valid}
   typedef struct packed {
      logic [2:0]  op;
      logic [7:0]  va;
      logic [7:0]  vb;
      logic        vc;
      logic [12:0] exp;
   } vec_t;

   eight_bit_alu dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .a         (a),
      .b         (b),
      .cin       (cin),
      .opcode    (opcode),
      .res       (res),
      .cout      (cout),
      .zero      (zero),
      .sign      (sign),
      .overflow  (overflow),
      .out_valid (out_valid)
   );

   always #5 clk = ~clk;

   function automatic logic [12:0] observed();
      return {res, cout, zero, sign, overflow, out_valid};
   endfunction

   task automatic step(input logic v, input logic [2:0] op, input logic [7:0] va,
                       input logic [7:0] vb, input logic vc);
      @(negedge clk);
      in_valid = v;
      opcode   = op;
      a        = va;
      b        = vb;
      cin      = vc;
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      #12;
      total++;
      if (observed() !== 13'h0) begin
         bad++;
         $display("FAIL reset_hold got=%h want=%h", observed(), 13'h0);
      end
      @(negedge clk);
      rst = 1'b0;
      step(1'b0, 3'b000, 8'h00, 8'h00, 1'b0);
      step(1'b0, 3'b000, 8'h00, 8'h00, 1'b0);
      total++;
      if (observed() !== 13'h0) begin
         bad++;
         $display("FAIL reset_release got=%h want=%h", observed(), 13'h0);
      end
   endtask

   task automatic run_vectors(input string name, input vec_t v[]);
      foreach (v[i]) begin
         step(1'b1, v[i].op, v[i].va, v[i].vb, v[i].vc);
         total++;
         if (observed() !== v[i].exp) begin
            bad++;
            $display("FAIL %s[%0d] got=%h want=%h", name, i, observed(), v[i].exp);
         end
      end
   endtask

   task automatic test_add();
      vec_t v[];
      v = new[4];
      v[0] = '{3'b000, 8'd10,  8'd5,   1'b0, {8'd15,  1'b0, 1'b0, 1'b0, 1'b0, 1'b1}};
      v[1] = '{3'b000, 8'hFF,  8'h01,  1'b0, {8'h00,  1'b1, 1'b1, 1'b0, 1'b0, 1'b1}};
      v[2] = '{3'b000, 8'h7F,  8'h01,  1'b0, {8'h80,  1'b0, 1'b0, 1'b1, 1'b1, 1'b1}};
      v[3] = '{3'b000, 8'h10,  8'h20,  1'b1, {8'h31,  1'b0, 1'b0, 1'b0, 1'b0, 1'b1}};
      run_vectors("add", v);
   endtask

   task automatic test_sub();
      vec_t v[];
      v = new[4];
      v[0] = '{3'b001, 8'd15,  8'd7,   1'b0, {8'd8,   1'b1, 1'b0, 1'b0, 1'b0, 1'b1}};
      v[1] = '{3'b001, 8'd5,   8'd7,   1'b0, {8'hFE,  1'b0, 1'b0, 1'b1, 1'b0, 1'b1}};
      v[2] = '{3'b001, 8'h80,  8'h01,  1'b0, {8'h7F,  1'b1, 1'b0, 1'b0, 1'b1, 1'b1}};
      v[3] = '{3'b001, 8'd15,  8'd7,   1'b1, {8'd7,   1'b1, 1'b0, 1'b0, 1'b0, 1'b1}};
      run_vectors("sub", v);
   endtask

   task automatic test_logic();
      vec_t v[];
      v = new[4];
      v[0] = '{3'b010, 8'd170, 8'd85,  1'b1, {8'h00,  1'b0, 1'b1, 1'b0, 1'b0, 1'b1}};
      v[1] = '{3'b011, 8'd170, 8'd85,  1'b1, {8'hFF,  1'b0, 1'b0, 1'b1, 1'b0, 1'b1}};
      v[2] = '{3'b100, 8'd170, 8'd85,  1'b1, {8'hFF,  1'b0, 1'b0, 1'b1, 1'b0, 1'b1}};
      v[3] = '{3'b101, 8'd170, 8'hFF,  1'b1, {8'd85,  1'b0, 1'b0, 1'b0, 1'b0, 1'b1}};
      run_vectors("logic", v);
   endtask

   task automatic test_back_to_back();
      vec_t v[];
      logic [12:0] held;
      v = new[6];
      v[0] = '{3'b110, 8'd100, 8'h33,  1'b1, {8'd101, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1}};
      v[1] = '{3'b111, 8'd100, 8'h33,  1'b1, {8'd99,  1'b1, 1'b0, 1'b0, 1'b0, 1'b1}};
      v[2] = '{3'b111, 8'd0,   8'h00,  1'b0, {8'hFF,  1'b0, 1'b0, 1'b1, 1'b0, 1'b1}};
      v[3] = '{3'b110, 8'hFF,  8'h00,  1'b0, {8'h00,  1'b1, 1'b1, 1'b0, 1'b0, 1'b1}};
      v[4] = '{3'b110, 8'h7F,  8'h00,  1'b0, {8'h80,  1'b0, 1'b0, 1'b1, 1'b1, 1'b1}};
      v[5] = '{3'b111, 8'h80,  8'h00,  1'b0, {8'h7F,  1'b1, 1'b0, 1'b0, 1'b1, 1'b1}};
      run_vectors("incdec", v);
      // Gap: result and flags of the last op held, out_valid low.
      held = {8'h7F, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
      step(1'b0, 3'b000, 8'h01, 8'h01, 1'b0);
      total++;
      if (observed() !== held) begin
         bad++;
         $display("FAIL gap_hold got=%h want=%h", observed(), held);
      end
      step(1'b1, 3'b000, 8'd1, 8'd2, 1'b0);
      total++;
      if (observed() !== {8'd3, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1}) begin
         bad++;
         $display("FAIL after_gap got=%h want=%h", observed(), {8'd3, 5'b00001});
      end
   endtask

   task automatic test_async_reset();
      step(1'b1, 3'b011, 8'h80, 8'h01, 1'b0);
      total++;
      if (observed() !== {8'h81, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1}) begin
         bad++;
         $display("FAIL pre_reset got=%h want=%h", observed(), {8'h81, 5'b00101});
      end
      // Assert mid-cycle, away from any edge, with an op queued on the inputs.
      #2;
      rst = 1'b1;
      #1;
      total++;
      if (observed() !== 13'h0) begin
         bad++;
         $display("FAIL async_clear got=%h want=%h", observed(), 13'h0);
      end
      @(negedge clk);
      rst = 1'b0;
      step(1'b1, 3'b000, 8'd20, 8'd22, 1'b0);
      total++;
      if (observed() !== {8'd42, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1}) begin
         bad++;
         $display("FAIL first_after_reset got=%h want=%h", observed(), {8'd42, 5'b00001});
      end
   endtask

   initial begin
      test_reset();
      test_add();
      test_sub();
      test_logic();
      test_back_to_back();
      test_async_reset();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL timeout");
      $fatal(1, "timeout");
   end

endmodule
